// File: rtl/nco_freq_meter_if.sv
// Bundles the enable/sample inputs and measurement results of nco_freq_meter.
// The master modport is the NCO/consumer side; the slave modport is the meter.
interface nco_freq_meter_if #(
  parameter int unsigned DAC_W = 4,
  parameter int unsigned CNT_W = 10,
  parameter int unsigned PER_W = 16
);
  logic             i_en;
  logic [DAC_W-1:0] i_dac;
  logic [CNT_W-1:0] o_freq_step;
  logic [PER_W-1:0] o_period;
  logic             o_valid;
  logic             o_overflow;
  logic             o_locked;

  modport master (
    output i_en,
    output i_dac,
    input  o_freq_step,
    input  o_period,
    input  o_valid,
    input  o_overflow,
    input  o_locked
  );

  modport slave (
    input  i_en,
    input  i_dac,
    output o_freq_step,
    output o_period,
    output o_valid,
    output o_overflow,
    output o_locked
  );
endinterface

// File: rtl/nco_freq_meter.sv
// Recovers an NCO tuning word from its DAC codes by counting hysteresis-comparator
// rising edges over a fixed gate window, and measures the edge-to-edge period.
module nco_freq_meter #(
  parameter int unsigned DAC_W     = 4,
  parameter int unsigned GATE_LOG2 = 16,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned PER_W     = 16,
  parameter int unsigned TH_HI     = 10,
  parameter int unsigned TH_LO     = 5
) (
  input logic            i_clk,
  input logic            i_rst,
  nco_freq_meter_if.slave bus
);

  localparam logic [GATE_LOG2-1:0] GateLast = '1;
  localparam logic [CNT_W-1:0]     CntMax   = '1;
  localparam logic [PER_W-1:0]     PerMax   = '1;
  localparam logic [DAC_W-1:0]     ThHi     = DAC_W'(TH_HI);
  localparam logic [DAC_W-1:0]     ThLo     = DAC_W'(TH_LO);

  typedef enum logic [1:0] {StIdle, StArm, StGate, StReport} state_e;

  state_e               state_q, state_d;
  logic [DAC_W-1:0]     dac_q, dac_d;
  logic                 cmp_q, cmp_d;
  logic                 rise_q, rise_d;
  logic [GATE_LOG2-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic                 ovf_q, ovf_d;
  logic [PER_W-1:0]     per_cnt_q, per_cnt_d;
  logic                 seen_q, seen_d;
  logic [CNT_W-1:0]     freq_step_q, freq_step_d;
  logic [PER_W-1:0]     period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 overflow_q, overflow_d;
  logic                 locked_q, locked_d;

  // Front end: input register, hysteresis comparator, registered rising-edge event.
  always_comb begin
    dac_d = bus.i_dac;
    cmp_d = cmp_q;
    if (dac_q >= ThHi) begin
      cmp_d = 1'b1;
    end else if (dac_q <= ThLo) begin
      cmp_d = 1'b0;
    end
    rise_d = cmp_d & ~cmp_q;
  end

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_d       = ovf_q;
    freq_step_d = freq_step_q;
    overflow_d  = overflow_q;
    valid_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.i_en) begin
          state_d = StArm;
        end
      end
      StArm: begin
        if (!cmp_q) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      StGate: begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        if (rise_q) begin
          if (edge_cnt_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + 1'b1;
          end
        end
        // Results are loaded on entry so they line up with the REPORT-cycle valid.
        if (gate_cnt_q == GateLast) begin
          state_d     = StReport;
          freq_step_d = edge_cnt_d;
          overflow_d  = ovf_d;
          valid_d     = 1'b1;
        end
      end
      StReport: begin
        state_d    = StGate;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_d      = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // Dropping enable discards the open window and keeps the last results.
    if (!bus.i_en) begin
      state_d     = StIdle;
      valid_d     = 1'b0;
      freq_step_d = freq_step_q;
      overflow_d  = overflow_q;
    end
  end

  // Period measurement and lock tracking, active from ARM onward.
  always_comb begin
    per_cnt_d = per_cnt_q;
    seen_d    = seen_q;
    period_d  = period_q;
    locked_d  = locked_q;

    if (state_q == StIdle) begin
      per_cnt_d = '0;
      seen_d    = 1'b0;
    end else if (rise_q) begin
      per_cnt_d = '0;
      seen_d    = 1'b1;
      if (seen_q) begin
        period_d = (per_cnt_q == PerMax) ? PerMax : per_cnt_q + 1'b1;
        locked_d = (per_cnt_q != PerMax);
      end
    end else if (per_cnt_q == PerMax) begin
      locked_d = 1'b0;
    end else begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    if (!bus.i_en) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      dac_q       <= '0;
      cmp_q       <= 1'b0;
      rise_q      <= 1'b0;
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      per_cnt_q   <= '0;
      seen_q      <= 1'b0;
      freq_step_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_q       <= dac_d;
      cmp_q       <= cmp_d;
      rise_q      <= rise_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      per_cnt_q   <= per_cnt_d;
      seen_q      <= seen_d;
      freq_step_q <= freq_step_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.o_freq_step = freq_step_q;
  assign bus.o_period    = period_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_overflow  = overflow_q;
  assign bus.o_locked    = locked_q;

endmodule

// File: tb/tb_nco_freq_meter.sv
// Directed bench for nco_freq_meter with a 4096-cycle gate so that every
// scenario fits in a short run; expected counts are derived from that gate.
module tb_nco_freq_meter;

  localparam int unsigned DacW     = 4;
  localparam int unsigned GateLog2 = 12;
  localparam int unsigned CntW     = 10;
  localparam int unsigned PerW     = 16;
  localparam int          WinCyc   = (1 << GateLog2) + 1;

  localparam int ModeConst  = 0;
  localparam int ModeSquare = 1;
  localparam int ModeNco    = 2;
  localparam int ModeNoise  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nco_freq_meter_if #(.DAC_W(DacW), .CNT_W(CntW), .PER_W(PerW)) bus ();

  nco_freq_meter #(
    .DAC_W    (DacW),
    .GATE_LOG2(GateLog2),
    .CNT_W    (CntW),
    .PER_W    (PerW),
    .TH_HI    (10),
    .TH_LO    (5)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // Stimulus settings owned by the main process.
  int mode        = ModeConst;
  int const_val   = 0;
  int sq_period   = 2;
  int sw          = 0;
  int restart_req = 0;

  // Waveform generator: updates i_dac 1 time unit after each rising edge.
  initial begin
    int        ph;
    int        seen;
    logic [11:0] acc;
    logic      tog;
    ph = 0; seen = 0; acc = '0; tog = 1'b0;
    bus.i_dac = '0;
    forever begin
      @(posedge clk);
      #1;
      if (seen != restart_req) begin
        ph = 0; acc = '0; tog = 1'b0; seen = restart_req;
      end
      case (mode)
        ModeConst:  bus.i_dac = DacW'(const_val);
        ModeSquare: begin
          bus.i_dac = (ph < sq_period / 2) ? 4'd0 : 4'd15;
          ph = (ph + 1) % sq_period;
        end
        ModeNco: begin
          acc = acc + 12'(sw);
          bus.i_dac = acc[11:8];
        end
        default: begin
          bus.i_dac = tog ? 4'd9 : 4'd7;
          tog = ~tog;
        end
      endcase
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcount   = 0;
  int lv       = 0;
  int pv       = 0;

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.o_valid) begin
      vcount++;
      pv = lv;
      lv = cyc;
    end
  endtask

  task automatic wait_valids(input int n, input int budget, output bit ok);
    int start;
    start = vcount;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (vcount - start >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reset with enable held high, then release reset and keep enable asserted.
  task automatic start_run(input int m, input int arg);
    rst = 1'b1;
    bus.i_en = 1'b1;
    mode = m;
    const_val = arg;
    sq_period = arg;
    sw = arg;
    restart_req++;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic chk_outputs(input string tag, input int f, input int p, input int ov,
                             input int lk, input int vd);
    chk({tag, "_freq"}, bus.o_freq_step, f, f);
    chk({tag, "_period"}, bus.o_period, p, p);
    chk({tag, "_overflow"}, bus.o_overflow, ov, ov);
    chk({tag, "_locked"}, bus.o_locked, lk, lk);
    chk({tag, "_valid"}, bus.o_valid, vd, vd);
  endtask

  typedef struct {
    int mode;
    int arg;
    int f_lo;
    int f_hi;
    int period;
    int locked;
    int ovf;
  } vec_t;

  initial begin
    vec_t vecs[5];
    bit   ok;
    int   v0;

    // 4096-cycle gate: square period 64 -> 64 edges; 640 -> 6..7; period 2 saturates.
    vecs[0] = '{ModeConst,  15,   0,    0,   0, 0, 0};
    vecs[1] = '{ModeSquare, 64,   64,   64,  64, 1, 0};
    vecs[2] = '{ModeSquare, 640,  6,    7,   640, 1, 0};
    vecs[3] = '{ModeNoise,  0,    0,    0,   0, 0, 0};
    vecs[4] = '{ModeSquare, 2,    1023, 1023, 2, 1, 1};

    bus.i_en = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_outputs("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      start_run(vecs[i].mode, vecs[i].arg);
      wait_valids(2, 3 * WinCyc, ok);
      if (!ok) begin
        chk($sformatf("v%0d_timeout", i), 0, 1, 1);
      end else begin
        chk($sformatf("v%0d_freq", i), bus.o_freq_step, vecs[i].f_lo, vecs[i].f_hi);
        chk($sformatf("v%0d_overflow", i), bus.o_overflow, vecs[i].ovf, vecs[i].ovf);
        chk($sformatf("v%0d_period", i), bus.o_period, vecs[i].period, vecs[i].period);
        chk($sformatf("v%0d_locked", i), bus.o_locked, vecs[i].locked, vecs[i].locked);
        chk($sformatf("v%0d_interval", i), lv - pv, WinCyc, WinCyc);
        tick();
        chk($sformatf("v%0d_valid_width", i), bus.o_valid, 0, 0);
      end
    end

    // NCO with a 12-bit accumulator: edge count tracks the tuning word.
    start_run(ModeNco, 16);
    wait_valids(2, 3 * WinCyc, ok);
    if (!ok) chk("nco16_timeout", 0, 1, 1);
    else begin
      chk("nco16_freq", bus.o_freq_step, 15, 17);
      chk("nco16_period", bus.o_period, 256, 256);
      chk("nco16_locked", bus.o_locked, 1, 1);
    end
    sw = 28;
    wait_valids(2, 3 * WinCyc, ok);
    if (!ok) chk("nco28_timeout", 0, 1, 1);
    else begin
      chk("nco28_freq", bus.o_freq_step, 27, 29);
      chk("nco28_locked", bus.o_locked, 1, 1);
    end

    // Mid-window enable drop, then mid-window reset: neither window may report.
    start_run(ModeSquare, 64);
    wait_valids(1, 2 * WinCyc, ok);
    if (!ok) chk("intr_timeout", 0, 1, 1);
    else chk("intr_first_freq", bus.o_freq_step, 64, 64);
    repeat (1000) tick();
    v0 = vcount;
    bus.i_en = 1'b0;
    tick();
    chk_outputs("en_drop", 64, 64, 0, 0, 0);
    bus.i_en = 1'b1;
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outputs("mid_reset", 0, 0, 0, 0, 0);
    repeat (3500) tick();
    chk("no_valid_interrupted", vcount - v0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nco_freq_meter.md
NCO_FREQ_METER -- requirements
Module: nco_freq_meter

Interface
REQ-001 Parameter DAC_W, default 4: width of sampled DAC code.
REQ-002 Parameter GATE_LOG2, default 16: gate window is 2^GATE_LOG2 clock cycles; set equal to the NCO phase-accumulator width so the edge count equals the tuning word.
REQ-003 Parameter CNT_W, default 10: width of the recovered frequency step.
REQ-004 Parameter PER_W, default 16: width of the period measurement.
REQ-005 Parameter TH_HI, default 10: the comparator goes high when sample >= TH_HI.
REQ-006 Parameter TH_LO, default 5: the comparator goes low when sample <= TH_LO; TH_LO < TH_HI.
REQ-007 i_clk  in  1  single clock for all logic.
REQ-008 i_rst  in  1  reset; synchronous, active-high.
REQ-009 i_en  in  1  measurement enable.
REQ-010 i_dac  in  DAC_W  unsigned DAC code from the NCO, sampled every cycle.
REQ-011 o_freq_step  out  CNT_W  rising-edge count of the last completed gate window.
REQ-012 o_period  out  PER_W  clocks between the last two rising edges.
REQ-013 o_valid  out  1  one-cycle pulse when o_freq_step updates.
REQ-014 o_overflow  out  1  edge count of the last window saturated.
REQ-015 o_locked  out  1  two or more edges seen since arming, with no period saturation.

Function
REQ-016 The block SHALL register i_dac once, then apply a hysteresis comparator to the registered sample; the comparator holds its state between TH_LO and TH_HI.
REQ-017 The block SHALL assert an edge event for one cycle on each comparator 0->1 transition; the event occurs 2 cycles after the triggering sample appears on i_dac.
REQ-018 The FSM SHALL have the states IDLE, ARM, GATE and REPORT.
REQ-019 IDLE: exit to ARM when i_en=1.
REQ-020 ARM: exit to GATE on the first cycle the comparator is low; the gate counter and edge counter are cleared on entry to GATE.
REQ-021 GATE: the gate counter increments every cycle from 0 to 2^GATE_LOG2-1, and the edge counter increments on each edge event.
REQ-022 GATE: the edge counter saturates at 2^CNT_W-1 and sets an internal overflow flag.
REQ-023 GATE: on the cycle the gate counter equals 2^GATE_LOG2-1, the FSM enters REPORT; an edge event on that cycle counts in the closing window.
REQ-024 REPORT (one cycle): load o_freq_step with the count, load o_overflow with the flag, pulse o_valid=1.
REQ-025 REPORT: return to GATE with counters cleared, so consecutive windows are contiguous apart from the single REPORT cycle.
REQ-026 i_en=0 in any state SHALL force IDLE on the next cycle.
REQ-027 When i_en drops, the window in progress SHALL be discarded without an o_valid pulse, and all outputs other than o_valid SHALL hold.
REQ-028 Period counter: free-running from ARM onward and saturating at 2^PER_W-1.
REQ-029 On each edge event, o_period SHALL load the counter value + 1 (clocks since the previous edge), and the counter SHALL restart at 0.
REQ-030 The first edge after ARM SHALL restart the counter without loading o_period.
REQ-031 o_locked SHALL set on the second edge after ARM and SHALL clear on period-counter saturation or on leaving GATE/REPORT for IDLE.
REQ-032 o_valid SHALL NOT be asserted outside REPORT.

Reset
REQ-033 i_rst=1 SHALL, on the next rising edge of i_clk, put the FSM in IDLE, clear all counters, the comparator state and the input register, and drive o_freq_step=0, o_period=0, o_valid=0, o_overflow=0, o_locked=0.
REQ-034 i_rst SHALL take priority over i_en; reset asserted mid-window SHALL produce no o_valid.

Verification
REQ-035 Constant i_dac=15, i_en=1 for 2 windows -> o_valid pulses every 2^16+1 cycles, o_freq_step=0, o_locked=0.
REQ-036 Square wave 0/15 with period 640 cycles -> o_freq_step=102 or 103, o_period=640, o_locked=1, o_overflow=0.
REQ-037 Codebase NCO with 16-bit accumulator, SW=64, driving i_dac (GATE_LOG2=16) -> o_freq_step=64+/-1 in every window; step to SW=114 -> the next full window reports 114+/-1.
REQ-038 Noise alternating 7/9 every cycle -> no edge events, o_freq_step=0.
REQ-039 Square wave period 32 cycles with CNT_W=10 -> o_freq_step=1023, o_overflow=1.
REQ-040 i_rst pulse, then i_en=0 pulse, each mid-window -> no o_valid for the interrupted window, and outputs match REQ-033 and REQ-027 respectively.
